fifo_uart_tx: RTL and testbench

Serial transmit stage that drains the byte FIFO and serializes each word onto an asynchronous UART line. It sits directly downstream of the FIFO:
- it watches `fifo_empty`;
- it issues single-cycle read strobes into the FIFO's `data_outen`;
- it captures `data_out`;
- it shifts the word out LSB-first with start, optional parity and stop bits.

Frames go out back-to-back while the FIFO holds data and transmission is enabled.

---
 rtl/fifo_uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/fifo_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
//   Shared definitions for the FIFO-fed UART transmitter:
//     - tx_state_t : transmitter state encoding
//     - LINE_IDLE / START_LEVEL / STOP_LEVEL : serial line levels
//   The PARITY encoding is always present; the transmitter only enters it when
//   built with UART_TX_PARITY_EN defined.
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
//   wraps by itself; bit_tick marks the last cycle of each bit period.
//
// Ports:
//   clock    in  : system clock, rising edge
//   reset_n  in  : asynchronous active-low reset
//   clear    in  : forces the count back to 0 on the next edge
//   bit_tick out : high while the count sits at its terminal value
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_tick = (count == TERM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drains a byte FIFO and serializes each word onto a UART line:
//   start bit, DATA_SIZE data bits LSB first, optional even parity, and
//   STOP_BITS stop bits. Frames run back-to-back while the FIFO holds data and
//   tx_enable is high.
//
//   Build option: define UART_TX_PARITY_EN to add one even-parity bit after
//   the data MSB. Without it DATA goes straight to STOP.
//
// Ports:
//   clock       in  : system clock, rising edge
//   reset_n     in  : asynchronous active-low reset
//   fifo_empty  in  : FIFO empty flag
//   fifo_rdata  in  : FIFO data_out, valid the cycle after fifo_rden
//   fifo_rden   out : one-cycle read strobe (FETCH state only)
//   tx_enable   in  : permits new frames to start
//   tx_serial   out : registered UART line, idles high
//   tx_busy     out : high in every state except IDLE
//   tx_done     out : pulse on the last cycle of the stop period
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rdata,
  output logic                 fifo_rden,
  input  logic                 tx_enable,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // The bit index doubles as the stop-bit counter, so it must hold both ranges.
  localparam int IDX_MAX = (DATA_SIZE > STOP_BITS) ? DATA_SIZE : STOP_BITS;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t            state;
  tx_state_t            state_n;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_n;
  logic [DATA_SIZE-1:0] shreg;
  logic                 load;
  logic                 line_n;
  logic                 bit_tick;
  logic                 baud_clear;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  // The counter only runs in the timed states and restarts on every state
  // change, so each state begins with a full bit period.
  assign baud_clear = (state_n != state) ||
                      (state == IDLE) || (state == FETCH) || (state == LOAD);

  assign fifo_rden = (state == FETCH);
  assign tx_busy   = (state != IDLE);

  // Next-state and strobes
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    load      = 1'b0;
    tx_done   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_n = FETCH;
        end
      end
      FETCH: begin
        state_n = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        bit_idx_n = '0;
        state_n   = START;
      end
      START: begin
        if (bit_tick) begin
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_DATA) begin
            bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          bit_idx_n = '0;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_idx == LAST_STOP) begin
            tx_done   = 1'b1;
            bit_idx_n = '0;
            state_n   = (tx_enable && !fifo_empty) ? FETCH : IDLE;
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Line level for the upcoming cycle. Registering it against state_n keeps
  // tx_serial aligned with the state it belongs to while staying glitch-free.
  always_comb begin
    line_n = LINE_IDLE;
    case (state_n)
      START:   line_n = START_LEVEL;
      DATA:    line_n = shreg[bit_idx_n];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_n = parity_bit;
`endif
      STOP:    line_n = STOP_LEVEL;
      default: line_n = LINE_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_idx   <= '0;
      tx_serial <= LINE_IDLE;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_idx_n;
      tx_serial <= line_n;
    end
  end

  // Data capture: fifo_rdata is valid during LOAD, one cycle after the strobe
  always_ff @(posedge clock) begin
    if (load) begin
      shreg <= fifo_rdata;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock) begin
    if (load) begin
      parity_bit <= ^fifo_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB      = 1;
  localparam int LIT_LEN = 44;
  localparam int LIT_GAP = 46;
`else
  localparam int PB      = 0;
  localparam int LIT_LEN = 40;
  localparam int LIT_GAP = 42;
`endif
  localparam int F = (1 + DW + PB + SB) * CPB;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rden;
  logic          tx_enable;
  logic          tx_serial;
  logic          tx_busy;
  logic          tx_done;

  always #5 clock = ~clock;

  fifo_uart_tx #(
    .DATA_SIZE   (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rden (fifo_rden),
    .tx_enable (tx_enable),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clock) begin
    if (fifo_rden) begin
      fifo_rdata <= mem[rd_ptr[7:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  int cyc_n = 0;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // A transaction is FETCH, LOAD, then an F-cycle frame; m_cyc is the offset
  // into it. Line level is derived from the frame offset arithmetically.
  bit         m_act  = 1'b0;
  int         m_cyc  = 0;
  int         m_ptr  = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] exp_q[$];

  always @(negedge clock) begin
    logic e_line, e_rden, e_busy, e_done;
    int k, b;
    e_line = 1'b1; e_rden = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (reset_n && m_act) begin
      e_busy = 1'b1;
      e_rden = (m_cyc == 0);
      e_done = (m_cyc == F + 1);
      k = m_cyc - 2;
      if (k >= 0) begin
        b = k / CPB;
        if (b == 0)                       e_line = 1'b0;
        else if (b <= DW)                 e_line = m_byte[b-1];
        else if (PB == 1 && b == DW + 1)  e_line = ^m_byte;
        else                              e_line = 1'b1;
      end
    end
    check("tx_serial", 32'(tx_serial), 32'(e_line));
    check("fifo_rden", 32'(fifo_rden), 32'(e_rden));
    check("tx_busy",   32'(tx_busy),   32'(e_busy));
    check("tx_done",   32'(tx_done),   32'(e_done));
    // advance to the next cycle using the inputs the DUT will sample
    if (!reset_n) begin
      if (m_act && exp_q.size() > 0) void'(exp_q.pop_back());
      m_act = 1'b0;
    end else if (!m_act || m_cyc == F + 1) begin
      if (tx_enable && !fifo_empty) begin
        m_act  = 1'b1;
        m_cyc  = 0;
        m_byte = mem[m_ptr[7:0]];
        m_ptr++;
        exp_q.push_back(m_byte);
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_cyc++;
    end
  end

  // ---------------- line decoder and event monitor ----------------
  bit         d_act = 1'b0;
  int         d_cnt = 0;
  int         d_start = 0;
  logic [7:0] d_byte = 8'h00;
  logic       d_par = 1'b0;
  logic [7:0] dec_log [0:255];
  logic       par_log [0:255];
  int         dec_n = 0;
  int         start_hist [0:255];
  int         start_n = 0;
  int         frame_len = 0;
  int         done_cnt = 0;
  int         rden_t [0:255];
  int         idle_at_rden [0:255];
  int         rden_n = 0;
  int         idle_total = 0;

  always @(negedge clock) begin
    int off, b;
    if (fifo_rden && rden_n < 256) begin
      rden_t[rden_n]       = cyc_n;
      idle_at_rden[rden_n] = idle_total;
      rden_n++;
    end
    if (!tx_busy) idle_total++;
    if (tx_done) begin
      done_cnt++;
      frame_len = cyc_n - d_start + 1;
    end
    if (!reset_n) begin
      d_act = 1'b0;
    end else if (!d_act) begin
      if (tx_serial == 1'b0) begin
        d_act   = 1'b1;
        d_cnt   = 0;
        d_start = cyc_n;
        if (start_n < 256) start_hist[start_n] = cyc_n;
        start_n++;
      end
    end else begin
      d_cnt++;
      off = d_cnt - CPB / 2;
      if (off >= 0 && (off % CPB) == 0) begin
        b = off / CPB;
        if (b == 0) begin
          check("start_bit", 32'(tx_serial), 32'(0));
        end else if (b <= DW) begin
          d_byte[b-1] = tx_serial;
        end else if (PB == 1 && b == DW + 1) begin
          d_par = tx_serial;
        end else begin
          check("stop_bit", 32'(tx_serial), 32'(1));
          dec_log[dec_n[7:0]] = d_byte;
          par_log[dec_n[7:0]] = d_par;
          dec_n++;
          check("expq_nonempty", 32'(exp_q.size() != 0), 32'(1));
          if (exp_q.size() != 0) check("decoded_byte", 32'(d_byte), 32'(exp_q.pop_front()));
          d_act = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_rden(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      if (fifo_rden) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_rden", 32'(ok), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, k0, s0, rel, pushes;
    bit drained;
    reset_n   = 1'b0;
    tx_enable = 1'b0;

    // 1. reset held with data waiting
    push(8'hF0);
    tx_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("rst_serial", 32'(tx_serial), 32'(1));
      check("rst_rden",   32'(fifo_rden), 32'(0));
      check("rst_busy",   32'(tx_busy),   32'(0));
      check("rst_done",   32'(tx_done),   32'(0));
    end
    tx_enable = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(3);

    // 2. single word 0xF0
    r0 = rden_n; d0 = done_cnt; k0 = dec_n;
    tx_enable = 1'b1;
    step(60);
    check("s2_rden_count", 32'(rden_n - r0), 32'(1));
    check("s2_done_count", 32'(done_cnt - d0), 32'(1));
    check("s2_dec_count",  32'(dec_n - k0), 32'(1));
    check("s2_byte",       32'(dec_log[k0[7:0]]), 32'h0F0);
    check("s2_frame_len",  32'(frame_len), 32'(LIT_LEN));

    // 3. burst 1..16
    r0 = rden_n; k0 = dec_n;
    for (int i = 1; i <= 16; i++) push(8'(i));
    step(16 * (F + 2) + 20);
    check("s3_rden_count", 32'(rden_n - r0), 32'(16));
    for (int i = 1; i < 16; i++)
      check("s3_rden_gap", 32'(rden_t[r0+i] - rden_t[r0+i-1]), 32'(LIT_GAP));
    for (int i = 0; i < 16; i++)
      check("s3_byte", 32'(dec_log[(k0+i) % 256]), 32'(i + 1));
    check("s3_no_idle", 32'(idle_at_rden[r0+15] - idle_at_rden[r0]), 32'(0));

    // 4. tx_enable dropped during bit 2 of 0x55
    r0 = rden_n; d0 = done_cnt; k0 = dec_n;
    push(8'h55); push(8'hA5); push(8'h3C);
    wait_rden(20);
    step(15);
    tx_enable = 1'b0;
    step(60);
    check("s4_rden_count", 32'(rden_n - r0), 32'(1));
    check("s4_done_count", 32'(done_cnt - d0), 32'(1));
    check("s4_byte",       32'(dec_log[k0[7:0]]), 32'h055);
    @(negedge clock);
    check("s4_line_idle",  32'(tx_serial), 32'(1));
    check("s4_not_busy",   32'(tx_busy), 32'(0));

    // 5. reset pulse during data bit 3 of 0xA5
    step(1);
    r0 = rden_n; k0 = dec_n;
    tx_enable = 1'b1;
    wait_rden(20);
    step(19);
    reset_n = 1'b0;
    #1;
    check("s5_rst_serial", 32'(tx_serial), 32'(1));
    check("s5_rst_busy",   32'(tx_busy), 32'(0));
    check("s5_rst_rden",   32'(fifo_rden), 32'(0));
    step(2);
    s0 = start_n;
    reset_n = 1'b1;
    rel = cyc_n;
    step(60);
    check("s5_start_delay", 32'(start_hist[s0[7:0]] - rel), 32'(3));
    check("s5_rden_count",  32'(rden_n - r0), 32'(2));
    check("s5_dec_count",   32'(dec_n - k0), 32'(1));
    check("s5_byte",        32'(dec_log[k0[7:0]]), 32'h03C);

`ifdef UART_TX_PARITY_EN
    // 6. parity frame for 0x07
    k0 = dec_n;
    push(8'h07);
    step(60);
    check("s6_byte",      32'(dec_log[k0[7:0]]), 32'h007);
    check("s6_parity",    32'(par_log[k0[7:0]]), 32'(1));
    check("s6_frame_len", 32'(frame_len), 32'(44));
`endif

    // randomized traffic with enable toggling
    pushes = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((wr_ptr - rd_ptr) < 6 && pushes < 60 && $urandom_range(0, 5) == 0) begin
        push(8'($urandom_range(0, 255)));
        pushes++;
      end
      tx_enable = ($urandom_range(0, 15) != 0);
      step(1);
    end
    tx_enable = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 20 * (F + 2); i++) begin
      @(negedge clock);
      if (fifo_empty && !tx_busy) begin
        drained = 1'b1;
        break;
      end
    end
    check("rand_drained",    32'(drained), 32'(1));
    check("rand_reads",      32'(rd_ptr), 32'(m_ptr));
    check("rand_expq_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
